complex_div: RTL
================

Name: complex_div

Overview:
- Computes the complex quotient q = a / b as a·conj(b) / |b|², with a fixed-point result.
- Inverse of the receive-path complex multiplier; used by the channel equaliser to divide each data subcarrier by its channel estimate.
- Iterative, one quotient bit per cycle, one operation in flight; a ready signal gates new inputs.

Parameters:
- FRAC_BITS, 14: fractional bits of q_i and q_q (q = num·2^FRAC_BITS / den).
- OUT_WIDTH, 16: signed width of q_i and q_q.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- enable  in  1  when 0, all registers and the FSM hold.
- a_i, a_q  in  16 each  dividend, signed.
- b_i, b_q  in  16 each  divisor, signed.
- input_strobe  in  1  operands valid; accepted only when input_ready=1.
- input_ready  out  1  FSM in IDLE.
- q_i, q_q  out  OUT_WIDTH each  quotient, signed, registered.
- output_strobe  out  1  one-cycle pulse, q valid.
- div_by_zero  out  1  last result had den=0.
- saturated  out  1  last result clamped in either component.

Behaviour:
- Reset values: q_i=0, q_q=0, output_strobe=0, div_by_zero=0, saturated=0, input_ready=1, FSM=IDLE. Applies immediately on assertion, including mid-operation; the aborted operation produces no strobe.
- FSM states: IDLE, MULT, PREP, DIV, DONE. All transitions are qualified by enable=1.
- IDLE: on input_strobe, latch the four operands and go to MULT. A strobe in any other state is silently dropped.
- MULT: register the four 32-bit signed products ar·br, ai·bi, ai·br, ar·bi, and br², bi².
- PREP:
  - num_i = ar·br + ai·bi (33-bit signed).
  - num_q = ai·br − ar·bi (33-bit signed).
  - den = br² + bi² (32-bit unsigned).
  - Record the sign of each numerator; load each dividend as |num| << FRAC_BITS; load the iteration counter with NB = 32 + FRAC_BITS.
- DIV: restoring unsigned division, both components in parallel against the shared den, MSB first. One bit per cycle; go to DONE after NB iterations.
- DONE:
  - Apply signs; quotient truncates toward zero.
  - If |q| > 2^(OUT_WIDTH−1)−1, clamp to ±(2^(OUT_WIDTH−1)−1) (symmetric) and set saturated.
  - If den=0: q_i=q_q=0, div_by_zero=1, saturated=0; the divide iterations still run, so latency is unchanged.
  - Assert output_strobe for one cycle and return to IDLE.
- q_i, q_q, div_by_zero and saturated hold their values until the next DONE.
- Latency with enable held high: strobe accepted at cycle T gives output_strobe at T+3+NB (49 cycles for FRAC_BITS=14). input_ready rises in the cycle after output_strobe. Throughput is one result per NB+4 cycles.
- enable low stretches latency by exactly the number of low cycles. output_strobe is asserted only on an enabled DONE cycle.

Optional Feature:
- Macro COMPLEX_DIV_ROUND_EN.
- Defined:
  - DIV runs NB+1 iterations, producing one guard bit.
  - The magnitude is rounded half away from zero (add the guard bit) before the sign is applied and before saturation.
  - Latency is T+4+NB.
- Undefined: truncation toward zero, latency T+3+NB.

Decomposition:
- Package complex_div_pkg:
  - FSM state enum.
  - Product, numerator and denominator width constants (32, 33, 32).
  - Function computing NB from FRAC_BITS.
- One sub-module, udiv_step: combinational single restoring-division step (remainder, divisor → next remainder, quotient bit). Instantiated twice, once for I and once for Q.

Test Plan (FRAC_BITS=14, OUT_WIDTH=16):
- a=(16384,0), b=(16384,0) -> q=(16384,0), output_strobe exactly 49 cycles after the accepted strobe, flags 0.
- a=(0,8192), b=(8192,0) -> q=(0,16384); a=(0,8192), b=(0,8192) -> q=(16384,0).
- a=(1000,2000), b=(0,1000) -> true quotient (2,−1) -> q=(32767,−16384), saturated=1.
- b=(0,0), any a -> q=(0,0), div_by_zero=1, latency still 49.
- a=(2,0), b=(3,0) -> q_i=10922 without the macro, 10923 with COMPLEX_DIV_ROUND_EN; a=(−2,0), b=(3,0) -> −10922 / −10923.
- Busy and reset handling:
  - A second strobe at T+10 is ignored; input_ready=0 until after the strobe.
  - reset=0 at T+20 clears all outputs and produces no output_strobe.
  - After release, a new operation completes with normal latency.

Source files
------------

// File: rtl/complex_div_pkg.sv
// Shared types and widths for the complex divider.
// Widths follow 16-bit signed operands: 32-bit products, 33-bit numerators, 32-bit denominator.
package complex_div_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_PREP,
        S_DIV,
        S_DONE
    } state_t;

    localparam int IN_W   = 16;
    localparam int PROD_W = 32;
    localparam int NUM_W  = 33;
    localparam int DEN_W  = 32;

    // Iterations needed for a full quotient of |num| << frac_bits over den.
    function automatic int calc_nb(input int frac_bits);
        return PROD_W + frac_bits;
    endfunction

endpackage

// File: rtl/complex_div_udiv_step.sv
// One restoring-division step: shift the next dividend bit into the remainder,
// subtract the divisor when it fits and emit the quotient bit.
module udiv_step
    import complex_div_pkg::*;
(
    input  logic [DEN_W-1:0] rem_in,
    input  logic             bit_in,
    input  logic [DEN_W-1:0] divisor,
    output logic [DEN_W-1:0] rem_out,
    output logic             q_bit
);

    logic [DEN_W:0]   trial;
    logic [DEN_W-1:0] diff;

    assign trial = {rem_in, bit_in};
    // The remainder always stays below the divisor, so the low word suffices for the difference.
    assign diff    = trial[DEN_W-1:0] - divisor;
    assign q_bit   = (trial >= {1'b0, divisor});
    assign rem_out = q_bit ? diff : trial[DEN_W-1:0];

endmodule

// File: rtl/complex_div.sv
// Iterative complex divider q = a*conj(b)/|b|^2, one quotient bit per cycle.
// Define COMPLEX_DIV_ROUND_EN to add a guard bit and round half away from zero.
//
// state | meaning
// IDLE  | ready, waiting for input_strobe
// MULT  | register partial products
// PREP  | form numerators/denominator, load dividends
// DIV   | one restoring step per cycle on I and Q
// DONE  | result valid, output_strobe high
module complex_div
    import complex_div_pkg::*;
#(
    parameter int FRAC_BITS = 14,
    parameter int OUT_WIDTH = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic signed [IN_W-1:0]      a_i,
    input  logic signed [IN_W-1:0]      a_q,
    input  logic signed [IN_W-1:0]      b_i,
    input  logic signed [IN_W-1:0]      b_q,
    input  logic                        input_strobe,
    output logic                        input_ready,
    output logic signed [OUT_WIDTH-1:0] q_i,
    output logic signed [OUT_WIDTH-1:0] q_q,
    output logic                        output_strobe,
    output logic                        div_by_zero,
    output logic                        saturated
);

    localparam int NB = calc_nb(FRAC_BITS);
`ifdef COMPLEX_DIV_ROUND_EN
    localparam int GUARD = 1;
`else
    localparam int GUARD = 0;
`endif
    localparam int QW    = NB + GUARD;
    localparam int CNT_W = $clog2(QW + 1);
    localparam logic [QW-1:0] MAX_MAG = {{(QW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};

    state_t state, state_nxt;

    logic signed [IN_W-1:0]   ar, ai, br, bi;
    logic signed [PROD_W-1:0] p_rr, p_ii, p_ir, p_ri;
    logic [PROD_W-1:0]        p_bb_i, p_bb_q;
    logic [DEN_W-1:0]         den, rem_i, rem_q, rem_nxt_i, rem_nxt_q;
    logic [QW-1:0]            quo_i, quo_q;
    logic [CNT_W-1:0]         cnt;
    logic                     neg_i, neg_q, den_zero, qb_i, qb_q;

    logic signed [NUM_W-1:0]  num_i, num_q;
    logic [PROD_W-1:0]        abs_i, abs_q;
    logic [DEN_W-1:0]         den_sum;

    assign num_i   = NUM_W'(p_rr) + NUM_W'(p_ii);
    assign num_q   = NUM_W'(p_ir) - NUM_W'(p_ri);
    assign abs_i   = num_i[NUM_W-1] ? PROD_W'(-num_i) : PROD_W'(num_i);
    assign abs_q   = num_q[NUM_W-1] ? PROD_W'(-num_q) : PROD_W'(num_q);
    assign den_sum = p_bb_i + p_bb_q;

    udiv_step u_step_i (
        .rem_in  (rem_i),
        .bit_in  (quo_i[QW-1]),
        .divisor (den),
        .rem_out (rem_nxt_i),
        .q_bit   (qb_i)
    );

    udiv_step u_step_q (
        .rem_in  (rem_q),
        .bit_in  (quo_q[QW-1]),
        .divisor (den),
        .rem_out (rem_nxt_q),
        .q_bit   (qb_q)
    );

    // Result is finalised from the last step's quotient so it is valid throughout DONE.
    logic [QW-1:0]               quo_nxt_i, quo_nxt_q, mag_i, mag_q;
    logic                        sat_i, sat_q;
    logic [OUT_WIDTH-1:0]        clip_i, clip_q;
    logic signed [OUT_WIDTH-1:0] res_i, res_q;

    assign quo_nxt_i = {quo_i[QW-2:0], qb_i};
    assign quo_nxt_q = {quo_q[QW-2:0], qb_q};
`ifdef COMPLEX_DIV_ROUND_EN
    assign mag_i = (quo_nxt_i >> 1) + QW'(quo_nxt_i[0]);
    assign mag_q = (quo_nxt_q >> 1) + QW'(quo_nxt_q[0]);
`else
    assign mag_i = quo_nxt_i;
    assign mag_q = quo_nxt_q;
`endif
    assign sat_i  = (mag_i > MAX_MAG);
    assign sat_q  = (mag_q > MAX_MAG);
    assign clip_i = sat_i ? MAX_MAG[OUT_WIDTH-1:0] : mag_i[OUT_WIDTH-1:0];
    assign clip_q = sat_q ? MAX_MAG[OUT_WIDTH-1:0] : mag_q[OUT_WIDTH-1:0];
    assign res_i  = neg_i ? -$signed(clip_i) : $signed(clip_i);
    assign res_q  = neg_q ? -$signed(clip_q) : $signed(clip_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        input_ready   = (state == S_IDLE);
        output_strobe = 1'b0;
        if (enable) begin
            case (state)
                S_IDLE: if (input_strobe) state_nxt = S_MULT;
                S_MULT: state_nxt = S_PREP;
                S_PREP: state_nxt = S_DIV;
                S_DIV:  if (cnt == CNT_W'(1)) state_nxt = S_DONE;
                S_DONE: begin
                    output_strobe = 1'b1;
                    state_nxt     = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ar <= '0; ai <= '0; br <= '0; bi <= '0;
            p_rr <= '0; p_ii <= '0; p_ir <= '0; p_ri <= '0;
            p_bb_i <= '0; p_bb_q <= '0;
            den <= '0; rem_i <= '0; rem_q <= '0;
            quo_i <= '0; quo_q <= '0; cnt <= '0;
            neg_i <= 1'b0; neg_q <= 1'b0; den_zero <= 1'b0;
            q_i <= '0; q_q <= '0;
            div_by_zero <= 1'b0; saturated <= 1'b0;
        end else if (enable) begin
            case (state)
                S_IDLE: if (input_strobe) begin
                    ar <= a_i; ai <= a_q; br <= b_i; bi <= b_q;
                end
                S_MULT: begin
                    p_rr   <= PROD_W'(ar) * PROD_W'(br);
                    p_ii   <= PROD_W'(ai) * PROD_W'(bi);
                    p_ir   <= PROD_W'(ai) * PROD_W'(br);
                    p_ri   <= PROD_W'(ar) * PROD_W'(bi);
                    p_bb_i <= $unsigned(PROD_W'(br) * PROD_W'(br));
                    p_bb_q <= $unsigned(PROD_W'(bi) * PROD_W'(bi));
                end
                S_PREP: begin
                    den      <= den_sum;
                    den_zero <= (den_sum == '0);
                    neg_i    <= num_i[NUM_W-1];
                    neg_q    <= num_q[NUM_W-1];
                    quo_i    <= {abs_i, {(FRAC_BITS+GUARD){1'b0}}};
                    quo_q    <= {abs_q, {(FRAC_BITS+GUARD){1'b0}}};
                    rem_i    <= '0;
                    rem_q    <= '0;
                    cnt      <= CNT_W'(QW);
                end
                S_DIV: begin
                    quo_i <= quo_nxt_i;
                    quo_q <= quo_nxt_q;
                    rem_i <= rem_nxt_i;
                    rem_q <= rem_nxt_q;
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        if (den_zero) begin
                            q_i <= '0;
                            q_q <= '0;
                            div_by_zero <= 1'b1;
                            saturated   <= 1'b0;
                        end else begin
                            q_i <= res_i;
                            q_q <= res_q;
                            div_by_zero <= 1'b0;
                            saturated   <= sat_i | sat_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
